// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: PC+4 or word-aligned redirect target,
// stall hold with a buffered redirect decision, and a saturating retire counter.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned UPD_DELAY    = 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             BUSYWAIT,
   input  logic             JUMP,
   input  logic             BRANCH_EQ,
   input  logic             BRANCH_NE,
   input  logic             ZERO,
   input  logic [31:0]      TARGET_ADDR,
   output logic [31:0]      PC,
   output logic [31:0]      PC_PLUS4,
   output logic             PC_VALID,
   output logic             REDIRECT,
   output logic             ALIGN_ERR,
   output logic [CNT_W-1:0] INSTR_COUNT
);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]       state;
   logic [31:0]      pc;
   logic             pc_valid;
   logic             redirect;
   logic             align_err;
   logic [CNT_W-1:0] cnt;
   logic             pend_valid;
   logic [31:0]      pend_tgt;
   logic             pend_err;

   logic             take;
   logic [31:0]      tgt_aligned;
   logic             tgt_misaligned;
   logic [31:0]      pc_plus4;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      take           = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
      tgt_aligned    = TARGET_ADDR & ~32'h3;
      tgt_misaligned = (TARGET_ADDR[1:0] != 2'b00);
      pc_plus4       = pc + 32'd4;
      cnt_next       = (cnt == '1) ? cnt : cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state      <= BOOT;
         pc         <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         redirect   <= 1'b0;
         align_err  <= 1'b0;
         cnt        <= '0;
         pend_valid <= 1'b0;
         pend_tgt   <= '0;
         pend_err   <= 1'b0;
      end else begin
         redirect  <= 1'b0;
         align_err <= 1'b0;
         case (state)
            BOOT: begin
               pc_valid <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               if (BUSYWAIT) begin
                  // Only the decision seen on the stall-entry cycle is kept.
                  pend_valid <= take;
                  pend_tgt   <= tgt_aligned;
                  pend_err   <= tgt_misaligned;
                  state      <= STALL;
               end else begin
                  pc        <= take ? tgt_aligned : pc_plus4;
                  redirect  <= take;
                  align_err <= take & tgt_misaligned;
                  cnt       <= cnt_next;
               end
            end
            STALL: begin
               if (!BUSYWAIT) begin
                  pc         <= pend_valid ? pend_tgt : pc_plus4;
                  redirect   <= pend_valid;
                  align_err  <= pend_valid & pend_err;
                  cnt        <= cnt_next;
                  pend_valid <= 1'b0;
                  pend_tgt   <= '0;
                  pend_err   <= 1'b0;
                  state      <= RUN;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   assign PC          = pc;
   assign PC_PLUS4    = pc_plus4;
   assign PC_VALID    = pc_valid;
   assign REDIRECT    = redirect;
   assign ALIGN_ERR   = align_err;
   assign INSTR_COUNT = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branches, stall buffering, wrap,
// alignment, reset during stall, and counter saturation on a narrow instance.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        busywait;
   logic        jump;
   logic        branch_eq;
   logic        branch_ne;
   logic        zero;
   logic [31:0] target_addr;

   logic [31:0] pc, pc_plus4;
   logic        pc_valid, redirect, align_err;
   logic [15:0] instr_count;

   logic [31:0] pc2, pc2_plus4;
   logic        pc2_valid, redirect2, align_err2;
   logic [3:0]  instr_count2;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .CNT_W        (16),
      .UPD_DELAY    (1)
   ) dut (
      .CLK         (clk),
      .RESET_N     (reset_n),
      .BUSYWAIT    (busywait),
      .JUMP        (jump),
      .BRANCH_EQ   (branch_eq),
      .BRANCH_NE   (branch_ne),
      .ZERO        (zero),
      .TARGET_ADDR (target_addr),
      .PC          (pc),
      .PC_PLUS4    (pc_plus4),
      .PC_VALID    (pc_valid),
      .REDIRECT    (redirect),
      .ALIGN_ERR   (align_err),
      .INSTR_COUNT (instr_count)
   );

   pc_sequencer #(
      .RESET_VECTOR (32'h0000_1000),
      .CNT_W        (4),
      .UPD_DELAY    (1)
   ) dut_sat (
      .CLK         (clk),
      .RESET_N     (reset_n),
      .BUSYWAIT    (busywait),
      .JUMP        (jump),
      .BRANCH_EQ   (branch_eq),
      .BRANCH_NE   (branch_ne),
      .ZERO        (zero),
      .TARGET_ADDR (target_addr),
      .PC          (pc2),
      .PC_PLUS4    (pc2_plus4),
      .PC_VALID    (pc2_valid),
      .REDIRECT    (redirect2),
      .ALIGN_ERR   (align_err2),
      .INSTR_COUNT (instr_count2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ctrl(input logic j, input logic beq, input logic bne, input logic z,
                       input logic [31:0] tgt, input logic bw);
      jump        = j;
      branch_eq   = beq;
      branch_ne   = bne;
      zero        = z;
      target_addr = tgt;
      busywait    = bw;
   endtask

   // Checks PC, REDIRECT, ALIGN_ERR and INSTR_COUNT of the main instance.
   task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_redir,
                               input logic e_aerr, input logic [15:0] e_cnt);
      check({tag, ".pc"}, pc, e_pc);
      check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e_redir});
      check({tag, ".align_err"}, {31'b0, align_err}, {31'b0, e_aerr});
      check({tag, ".count"}, {16'b0, instr_count}, {16'b0, e_cnt});
   endtask

   int unsigned exp_cnt2;

   initial begin
      reset_n = 1'b0;
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      step();
      expect_state("reset", 32'h0, 1'b0, 1'b0, 16'd0);
      check("reset.valid", {31'b0, pc_valid}, 32'd0);
      check("reset.pc2", pc2, 32'h0000_1000);

      // Boot: one held cycle, then sequential fetch
      reset_n = 1'b1;
      step();
      expect_state("boot", 32'h0, 1'b0, 1'b0, 16'd0);
      check("boot.valid", {31'b0, pc_valid}, 32'd1);
      step();
      expect_state("seq1", 32'h4, 1'b0, 1'b0, 16'd1);
      step();
      expect_state("seq2", 32'h8, 1'b0, 1'b0, 16'd2);
      check("seq2.plus4", pc_plus4, 32'hC);

      // Taken beq, then not-taken beq
      ctrl(1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 1'b0);
      step();
      expect_state("beq_taken", 32'h18, 1'b1, 1'b0, 16'd3);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("after_beq", 32'h1C, 1'b0, 1'b0, 16'd4);
      ctrl(1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 1'b0);
      step();
      expect_state("beq_not_taken", 32'h20, 1'b0, 1'b0, 16'd5);

      // bne taken at stall entry; inputs change mid-stall and must be ignored
      ctrl(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1);
      step();
      expect_state("stall1", 32'h20, 1'b0, 1'b0, 16'd5);
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 1'b1);
      step();
      expect_state("stall2", 32'h20, 1'b0, 1'b0, 16'd5);
      step();
      expect_state("stall3", 32'h20, 1'b0, 1'b0, 16'd5);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("stall_release", 32'h40, 1'b1, 1'b0, 16'd6);
      step();
      expect_state("post_stall", 32'h44, 1'b0, 1'b0, 16'd7);

      // PC+4 wrap at the top of the address space
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
      step();
      expect_state("jump_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd8);
      check("top.plus4", pc_plus4, 32'h0);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("wrap", 32'h0, 1'b0, 1'b0, 16'd9);

      // Misaligned jump target is forced aligned and flagged
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h23, 1'b0);
      step();
      expect_state("jump_misaligned", 32'h20, 1'b1, 1'b1, 16'd10);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("after_misaligned", 32'h24, 1'b0, 1'b0, 16'd11);

      // JUMP together with a not-taken branch still redirects
      ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0);
      step();
      expect_state("jump_and_beq", 32'h100, 1'b1, 1'b0, 16'd12);

      // Misaligned target captured at stall entry flags on release
      ctrl(1'b0, 1'b1, 1'b0, 1'b1, 32'h51, 1'b1);
      step();
      expect_state("stall_mis_entry", 32'h100, 1'b0, 1'b0, 16'd12);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("stall_mis_release", 32'h50, 1'b1, 1'b1, 16'd13);

      // Stall without a taken decision resumes sequentially
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1);
      step();
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("stall_seq", 32'h54, 1'b0, 1'b0, 16'd14);

      // Reset in the middle of a stall discards the pending redirect
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1);
      step();
      expect_state("pend_entry", 32'h54, 1'b0, 1'b0, 16'd14);
      reset_n = 1'b0;
      step();
      expect_state("mid_stall_reset", 32'h0, 1'b0, 1'b0, 16'd0);
      check("mid_stall_reset.valid", {31'b0, pc_valid}, 32'd0);
      check("mid_stall_reset.pc2", pc2, 32'h0000_1000);
      reset_n = 1'b1;
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      expect_state("reboot", 32'h0, 1'b0, 1'b0, 16'd0);
      step();
      expect_state("no_pending_load", 32'h4, 1'b0, 1'b0, 16'd1);
      check("pc2_run", pc2, 32'h0000_1004);

      // Narrow counter saturates at 4'hF and stays there
      exp_cnt2 = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         exp_cnt2 = (exp_cnt2 < 15) ? exp_cnt2 + 1 : 15;
         check($sformatf("sat_cnt[%0d]", i), {28'b0, instr_count2}, exp_cnt2);
      end
      check("sat_pc2", pc2, 32'h0000_1004 + 32'd80);
      check("wide_cnt", {16'b0, instr_count}, 32'd21);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
